adder_datapath: RTL and testbench
=================================

Name: adder_datapath

Overview:
- Datapath stage directly downstream of the adding-machine Controller.
- Holds the program counter (PC), instruction register (IR), accumulator (ACC), the ALU and the address and bus muxes.
- Every control strobe it consumes comes from the Controller, and it returns the opcode field to the Controller.
- Drives the external memory address, write data and read/write strobes.

Parameters:
- WORD_W, 8, data/instruction word width.
- OPC_W, 3, opcode field width (IR[WORD_W-1 -: OPC_W]).
- ADDR_W, 5, address field width (IR[ADDR_W-1:0]); must equal WORD_W-OPC_W.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_IR  in  1  IR <= bus_value.
- load_acc  in  1  ACC <= acc_in.
- ld_pc  in  1  PC <= IR address field.
- clr_pc  in  1  PC <= 0.
- inc_pc  in  1  PC <= PC+1.
- sel_alu  in  1  acc_in source: 1 = ALU result, 0 = bus_value.
- sel_bus  in  1  bus_value source: 1 = ACC, 0 = mem_rdata.
- pass_add  in  1  ALU op: 1 = ACC+bus_value, 0 = pass bus_value.
- ir_on_adr  in  1  mem_addr <= IR address field.
- pc_on_adr  in  1  mem_addr <= PC.
- mem_read  in  1  read strobe from Controller.
- mem_write  in  1  write strobe from Controller.
- mem_rdata  in  WORD_W  memory read data.
- opcode  out  OPC_W  IR opcode field, to Controller.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  WORD_W  always ACC.
- mem_re  out  1  = mem_read.
- mem_we  out  1  = mem_write.
- acc_out  out  WORD_W  ACC value (observation).
- pc_out  out  ADDR_W  PC value (observation).
- carry  out  1  registered carry of last ADD.
- addr_conflict  out  1  sticky error flag.

Behaviour:
- Reset (reset=0, asynchronous): PC, IR, ACC, carry and addr_conflict all clear to 0.
  - While in reset: opcode=0, mem_addr=0 (PC), mem_wdata=0, acc_out=0, pc_out=0.
  - mem_re and mem_we follow their inputs combinationally, even during reset.
  - Release is synchronous-safe: the first update occurs on the first rising edge after reset goes high.
  - Reset asserted mid-operation discards any pending update that cycle.
- Combinational paths (zero latency):
  - bus_value = sel_bus ? ACC : mem_rdata.
  - alu = pass_add ? ACC + bus_value (WORD_W+1 bits) : {1'b0, bus_value}.
  - acc_in = sel_alu ? alu[WORD_W-1:0] : bus_value.
  - mem_addr:
    - ir_on_adr=1 → IR[ADDR_W-1:0].
    - else pc_on_adr=1 → PC.
    - else → 0.
  - mem_wdata = ACC. opcode = IR[WORD_W-1 -: OPC_W]. mem_re = mem_read. mem_we = mem_write.
- Registers (one-cycle latency, update on the rising clock edge):
  - PC priority: clr_pc > ld_pc > inc_pc > hold.
    - inc wraps 2^ADDR_W-1 → 0 with no flag.
    - ld_pc uses the IR value from before the edge, even if load_IR is asserted the same cycle.
  - IR: load_IR → bus_value, else hold.
  - ACC: load_acc → acc_in, else hold.
  - carry:
    - Updated only when load_acc & sel_alu & pass_add; takes alu[WORD_W].
    - A pass or bus load leaves carry unchanged.
    - ADD overflow wraps ACC modulo 2^WORD_W.
  - addr_conflict: set when ir_on_adr & pc_on_adr at a clock edge; cleared only by reset.
- Simultaneous events:
  - load_IR, load_acc and a PC op in the same cycle are independent; all take effect together.
  - mem_read & mem_write together are passed through unchanged; arbitrating them is the memory's concern.

Decomposition:
- Shared package adding_machine_pkg:
  - WORD_W, OPC_W, ADDR_W.
  - Opcode constants: OP_ADD=3'b000, OP_LOAD=3'b001, OP_STORE=3'b010.
  - Controller state encoding shared with the Controller.
- One natural sub-module, pc_counter: handles clr/ld/inc priority and wrap. IR, ACC, ALU and the muxes stay inline.

Test Plan:
- Reset: hold reset=0 with random inputs and clocks → PC=0, IR=0, ACC=0, carry=0, addr_conflict=0, opcode=0, mem_addr=0. After release with no strobes, everything holds.
- Fetch: PC=3, pc_on_adr=1, mem_rdata=8'b001_10110, load_IR=1, inc_pc=1, one clock → mem_addr=3 before the edge; after the edge IR=0x36, opcode=3'b001, PC=4.
- Load then ADD:
  - IR addr=0x16, ir_on_adr=1, mem_rdata=0xF0, load_acc=1, sel_alu=0 → mem_addr=0x16, ACC=0xF0.
  - Then mem_rdata=0x20, sel_alu=1, pass_add=1, load_acc=1 → ACC=0x10, carry=1.
- Store: ACC=0x5A, ir_on_adr=1, mem_write=1 → mem_we=1, mem_wdata=0x5A, mem_addr=IR[4:0], same cycle.
- PC priority and wrap:
  - PC=31, inc_pc=1 → PC=0.
  - clr_pc=ld_pc=inc_pc=1 → PC=0.
  - ld_pc=inc_pc=1 with IR addr=9 → PC=9.
- Conflict and async reset:
  - ir_on_adr=pc_on_adr=1 → mem_addr=IR addr; addr_conflict=1 after the edge and stays 1.
  - Pulse reset=0 mid-cycle → all registers and addr_conflict clear immediately, without a clock edge.

Source files
------------

// File: rtl/adding_machine_pkg.sv
// adding_machine_pkg: widths, opcodes and controller state encoding shared across the adding machine
package adding_machine_pkg;
  localparam int WORD_W = 8;
  localparam int OPC_W = 3;
  localparam int ADDR_W = 5;
  localparam logic [OPC_W-1:0] OP_ADD = 3'b000;
  localparam logic [OPC_W-1:0] OP_LOAD = 3'b001;
  localparam logic [OPC_W-1:0] OP_STORE = 3'b010;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_ADD,
    S_EXEC_LOAD,
    S_EXEC_STORE
  } ctrl_state_t;
endpackage

// File: rtl/adder_datapath_pc_counter.sv
// pc_counter: program counter with clr > ld > inc priority, wrapping silently
module pc_counter
  import adding_machine_pkg::*;
#(
  parameter int AW = ADDR_W
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          ld,
  input  logic          inc,
  input  logic [AW-1:0] ld_val,
  output logic [AW-1:0] pc
);
  logic [AW-1:0] pc_d, pc_q;
  always_comb pc_d = clr ? '0 : ld ? ld_val : inc ? pc_q + AW'(1) : pc_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) pc_q <= '0;
    else pc_q <= pc_d;
  assign pc = pc_q;
endmodule

// File: rtl/adder_datapath.sv
// adder_datapath: PC, IR, ACC, ALU and address/bus muxes driven by the adding-machine controller
module adder_datapath
  import adding_machine_pkg::*;
#(
  parameter int WORD_W = adding_machine_pkg::WORD_W,
  parameter int OPC_W  = adding_machine_pkg::OPC_W,
  parameter int ADDR_W = adding_machine_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_IR,
  input  logic              load_acc,
  input  logic              ld_pc,
  input  logic              clr_pc,
  input  logic              inc_pc,
  input  logic              sel_alu,
  input  logic              sel_bus,
  input  logic              pass_add,
  input  logic              ir_on_adr,
  input  logic              pc_on_adr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [WORD_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              carry,
  output logic              addr_conflict
);
  logic [WORD_W-1:0] ir_d, ir_q, acc_d, acc_q, bus_value, acc_in;
  logic [WORD_W:0]   alu;
  logic              carry_d, carry_q, conflict_d, conflict_q;
  logic [ADDR_W-1:0] pc;
  pc_counter #(.AW(ADDR_W)) u_pc (
    .clock (clock),
    .reset (reset),
    .clr   (clr_pc),
    .ld    (ld_pc),
    .inc   (inc_pc),
    .ld_val(ir_q[ADDR_W-1:0]),
    .pc    (pc)
  );
  always_comb begin
    bus_value  = sel_bus ? acc_q : mem_rdata;
    alu        = pass_add ? {1'b0, acc_q} + {1'b0, bus_value} : {1'b0, bus_value};
    acc_in     = sel_alu ? alu[WORD_W-1:0] : bus_value;
    ir_d       = load_IR ? bus_value : ir_q;
    acc_d      = load_acc ? acc_in : acc_q;
    carry_d    = (load_acc & sel_alu & pass_add) ? alu[WORD_W] : carry_q;
    conflict_d = conflict_q | (ir_on_adr & pc_on_adr);
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      ir_q       <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      conflict_q <= conflict_d;
    end
  assign mem_addr      = ir_on_adr ? ir_q[ADDR_W-1:0] : pc_on_adr ? pc : '0;
  assign opcode        = ir_q[WORD_W-1 -: OPC_W];
  assign mem_wdata     = acc_q;
  assign mem_re        = mem_read;
  assign mem_we        = mem_write;
  assign acc_out       = acc_q;
  assign pc_out        = pc;
  assign carry         = carry_q;
  assign addr_conflict = conflict_q;
endmodule

// File: tb/tb_adder_datapath.sv
// tb_adder_datapath: scoreboard bench comparing registered state against a reference model each cycle
module tb_adder_datapath;
  logic       clock = 1'b0;
  logic       reset;
  logic       load_IR, load_acc, ld_pc, clr_pc, inc_pc, sel_alu, sel_bus, pass_add;
  logic       ir_on_adr, pc_on_adr, mem_read, mem_write;
  logic [7:0] mem_rdata;
  logic [2:0] opcode;
  logic [4:0] mem_addr, pc_out;
  logic [7:0] mem_wdata, acc_out;
  logic       mem_re, mem_we, carry, addr_conflict;
  typedef struct {
    logic [4:0] pc;
    logic [2:0] opc;
    logic [7:0] acc;
    logic       c;
    logic       f;
  } exp_t;
  exp_t       sb[$];
  logic [4:0] m_pc;
  logic [7:0] m_ir, m_acc;
  logic       m_c, m_f;
  int         n_chk = 0, n_pass = 0;
  adder_datapath dut (
    .clock(clock), .reset(reset), .load_IR(load_IR), .load_acc(load_acc), .ld_pc(ld_pc),
    .clr_pc(clr_pc), .inc_pc(inc_pc), .sel_alu(sel_alu), .sel_bus(sel_bus), .pass_add(pass_add),
    .ir_on_adr(ir_on_adr), .pc_on_adr(pc_on_adr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .opcode(opcode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .acc_out(acc_out), .pc_out(pc_out), .carry(carry),
    .addr_conflict(addr_conflict)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic idle();
    {load_IR, load_acc, ld_pc, clr_pc, inc_pc, sel_alu, sel_bus, pass_add} = '0;
    {ir_on_adr, pc_on_adr, mem_read, mem_write} = '0;
    mem_rdata = '0;
  endtask
  task automatic model_zero();
    m_pc = '0; m_ir = '0; m_acc = '0; m_c = 1'b0; m_f = 1'b0;
  endtask
  task automatic cyc(input string tag);
    logic [7:0] bus, n_ir, n_acc;
    logic [8:0] alu;
    logic [4:0] n_pc;
    exp_t       e;
    bus   = sel_bus ? m_acc : mem_rdata;
    alu   = pass_add ? {1'b0, m_acc} + {1'b0, bus} : {1'b0, bus};
    n_acc = load_acc ? (sel_alu ? alu[7:0] : bus) : m_acc;
    n_ir  = load_IR ? bus : m_ir;
    n_pc  = clr_pc ? 5'd0 : ld_pc ? m_ir[4:0] : inc_pc ? m_pc + 5'd1 : m_pc;
    e.pc  = n_pc;
    e.opc = n_ir[7:5];
    e.acc = n_acc;
    e.c   = (load_acc && sel_alu && pass_add) ? alu[8] : m_c;
    e.f   = m_f | (ir_on_adr & pc_on_adr);
    sb.push_back(e);
    m_pc = n_pc; m_ir = n_ir; m_acc = n_acc; m_c = e.c; m_f = e.f;
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check({tag, ".pc"}, 32'(pc_out), 32'(e.pc));
    check({tag, ".opc"}, 32'(opcode), 32'(e.opc));
    check({tag, ".acc"}, 32'(acc_out), 32'(e.acc));
    check({tag, ".carry"}, 32'(carry), 32'(e.c));
    check({tag, ".conf"}, 32'(addr_conflict), 32'(e.f));
    idle();
  endtask
  task automatic check_zero(input string tag);
    check({tag, ".pc"}, 32'(pc_out), 0);
    check({tag, ".opc"}, 32'(opcode), 0);
    check({tag, ".acc"}, 32'(acc_out), 0);
    check({tag, ".wdata"}, 32'(mem_wdata), 0);
    check({tag, ".carry"}, 32'(carry), 0);
    check({tag, ".conf"}, 32'(addr_conflict), 0);
  endtask
  initial begin
    idle();
    model_zero();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      {load_IR, load_acc, ld_pc, clr_pc, inc_pc, sel_alu, sel_bus, pass_add} = 8'($urandom);
      {ir_on_adr, mem_read, mem_write} = 3'($urandom);
      mem_rdata = 8'($urandom);
      pc_on_adr = 1'b1;
      @(posedge clock);
      #1;
      check_zero("rst");
      check("rst.addr", 32'(mem_addr), 0);
      check("rst.re", 32'(mem_re), 32'(mem_read));
      check("rst.we", 32'(mem_we), 32'(mem_write));
    end
    idle();
    @(negedge clock);
    reset = 1'b1;
    cyc("hold0");
    cyc("hold1");
    repeat (3) begin
      inc_pc = 1'b1;
      cyc("inc");
    end
    pc_on_adr = 1'b1; mem_rdata = 8'b001_10110; load_IR = 1'b1; inc_pc = 1'b1;
    #1 check("fetch.addr", 32'(mem_addr), 3);
    cyc("fetch");
    ir_on_adr = 1'b1; mem_rdata = 8'hF0; load_acc = 1'b1;
    #1 check("load.addr", 32'(mem_addr), 32'h16);
    cyc("load");
    mem_rdata = 8'h20; sel_alu = 1'b1; pass_add = 1'b1; load_acc = 1'b1;
    cyc("add_ovf");
    mem_rdata = 8'h5A; load_acc = 1'b1;
    cyc("load5a");
    mem_rdata = 8'h11; sel_alu = 1'b1; load_acc = 1'b1;
    cyc("pass_keeps_c");
    mem_rdata = 8'h5A; load_acc = 1'b1;
    cyc("load5a_b");
    ir_on_adr = 1'b1; mem_write = 1'b1;
    #1;
    check("store.we", 32'(mem_we), 1);
    check("store.re", 32'(mem_re), 0);
    check("store.wdata", 32'(mem_wdata), 32'h5A);
    check("store.addr", 32'(mem_addr), 32'h16);
    mem_read = 1'b1;
    #1;
    check("rw.re", 32'(mem_re), 1);
    check("rw.we", 32'(mem_we), 1);
    cyc("store");
    sel_bus = 1'b1; sel_alu = 1'b1; pass_add = 1'b1; load_acc = 1'b1;
    cyc("acc_dbl");
    #1 check("noadr", 32'(mem_addr), 0);
    mem_rdata = 8'h1F; load_IR = 1'b1;
    cyc("ir1f");
    ld_pc = 1'b1;
    cyc("ld31");
    inc_pc = 1'b1;
    cyc("wrap");
    ld_pc = 1'b1;
    cyc("ld31b");
    clr_pc = 1'b1; ld_pc = 1'b1; inc_pc = 1'b1;
    cyc("clr_pri");
    mem_rdata = 8'h09; load_IR = 1'b1;
    cyc("ir09");
    ld_pc = 1'b1; inc_pc = 1'b1;
    cyc("ld_pri");
    mem_rdata = 8'hFF; load_IR = 1'b1; ld_pc = 1'b1;
    cyc("ld_old_ir");
    ir_on_adr = 1'b1; pc_on_adr = 1'b1;
    #1 check("conf.addr", 32'(mem_addr), 32'h1F);
    cyc("conf");
    cyc("conf_sticky");
    mem_rdata = 8'hC3; load_acc = 1'b1; inc_pc = 1'b1;
    cyc("pre_rst");
    @(posedge clock);
    #3;
    load_acc = 1'b1; mem_rdata = 8'h77;
    reset = 1'b0;
    #1 check_zero("async");
    #2 check_zero("async_hold");
    idle();
    model_zero();
    @(negedge clock);
    reset = 1'b1;
    cyc("post_rst");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
